// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin share of the single UDP core transmit port between
//   requester 0 (command replies) and requester 1 (periodic telemetry).
// Latency: req -> ack 1 cycle; first byte +3; last byte +NB+2; eth_tx_req +NB+4; done +NB+5.
// Backpressure: eth_tx_data_rdy low holds the byte stream; eth_tx_req_rdy gates frame start
//   (timeout-protected before the first byte, unbounded once the payload is loaded).
//
// Ports:
//   clk50m, rst             clock and synchronous active-high reset
//   reqN / ackN             level request held until the 1-cycle grant pulse
//   ipN, portN, dataN       destination and payload, sampled on the grant edge
//   doneN / errN            1-cycle pulse: frame handed to core / aborted on ready timeout
//   busy                    high whenever a frame is in flight
//   eth_tx_*                byte stream and frame request towards the UDP core
module udp_tx_scheduler #(
  parameter int          BUFFER_SIZE = 80,
  parameter logic [31:0] RDY_TIMEOUT = 32'd50000
) (
  input  logic                   clk50m,
  input  logic                   rst,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [31:0]            ip0,
  input  logic [31:0]            ip1,
  input  logic [15:0]            port0,
  input  logic [15:0]            port1,
  input  logic [BUFFER_SIZE-1:0] data0,
  input  logic [BUFFER_SIZE-1:0] data1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   done0,
  output logic                   done1,
  output logic                   err0,
  output logic                   err1,
  output logic                   busy,
  output logic [31:0]            eth_tx_ip,
  output logic [15:0]            eth_tx_dst_port,
  output logic [7:0]             eth_tx_data,
  output logic                   eth_tx_data_av,
  output logic                   eth_tx_req,
  input  logic                   eth_tx_req_rdy,
  input  logic                   eth_tx_data_rdy
);

  localparam logic [7:0] NB = 8'(BUFFER_SIZE / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_SEND,
    S_START,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic                   sel_q;     // index of the requester being served
  logic                   rr_q;      // index preferred when both request (0 after reset)
  logic [1:0]             ack_q;
  logic [1:0]             done_q;
  logic [1:0]             err_q;
  logic [31:0]            ip_q;
  logic [15:0]            port_q;
  logic [BUFFER_SIZE-1:0] shreg_q;
  logic [7:0]             cnt_q;
  logic [31:0]            tmo_q;
  logic [7:0]             data_q;
  logic                   av_q;
  logic                   req_q;

  logic                   gnt_sel_d;
  logic [31:0]            tmo_d;

  // A lone requester always wins; a tie goes to the preferred index.
  always_comb begin
    gnt_sel_d = req1;
    if (req0 && req1) begin
      gnt_sel_d = rr_q;
    end
  end

  // Saturating so the counter can never wrap past the limit.
  assign tmo_d = (tmo_q < RDY_TIMEOUT) ? tmo_q + 32'd1 : tmo_q;

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      ip_q    <= '0;
      port_q  <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      av_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      ack_q  <= '0;
      done_q <= '0;
      err_q  <= '0;
      av_q   <= 1'b0;
      req_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            sel_q            <= gnt_sel_d;
            ip_q             <= gnt_sel_d ? ip1 : ip0;
            port_q           <= gnt_sel_d ? port1 : port0;
            shreg_q          <= gnt_sel_d ? data1 : data0;
            ack_q[gnt_sel_d] <= 1'b1;
            tmo_q            <= '0;
            state_q          <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          if (eth_tx_req_rdy) begin
            cnt_q   <= '0;
            state_q <= S_SEND;
          end else begin
            tmo_q <= tmo_d;
            if (tmo_d >= RDY_TIMEOUT) begin
              err_q[sel_q] <= 1'b1;
              rr_q         <= ~sel_q;
              state_q      <= S_IDLE;
            end
          end
        end

        S_SEND: begin
          // Count check comes first so a late data_rdy can never add a byte.
          if (cnt_q == NB) begin
            state_q <= S_START;
          end else if (eth_tx_data_rdy) begin
            av_q    <= 1'b1;
            data_q  <= shreg_q[BUFFER_SIZE-1 -: 8];
            shreg_q <= shreg_q << 8;
            cnt_q   <= cnt_q + 8'd1;
          end
        end

        S_START: begin
          if (eth_tx_req_rdy) begin
            req_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          done_q[sel_q] <= 1'b1;
          rr_q          <= ~sel_q;
          state_q       <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0            = ack_q[0];
  assign ack1            = ack_q[1];
  assign done0           = done_q[0];
  assign done1           = done_q[1];
  assign err0            = err_q[0];
  assign err1            = err_q[1];
  assign busy            = (state_q != S_IDLE);
  assign eth_tx_ip       = ip_q;
  assign eth_tx_dst_port = port_q;
  assign eth_tx_data     = data_q;
  assign eth_tx_data_av  = av_q;
  assign eth_tx_req      = req_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb_udp_tx_scheduler: randomized and directed stimulus for udp_tx_scheduler, checked
//   against a frame-level reference model (arbitration by rule, payload bytes by arithmetic).
// Ports: none; drives every DUT input, samples outputs away from the rising edge.
module tb_udp_tx_scheduler;

  localparam int BS  = 80;
  localparam int NB  = BS / 8;
  localparam int TMO = 50000;

  logic          clk50m = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [31:0]   ip0, ip1;
  logic [15:0]   port0, port1;
  logic [BS-1:0] data0, data1;
  logic          ack0, ack1, done0, done1, err0, err1, busy;
  logic [31:0]   eth_tx_ip;
  logic [15:0]   eth_tx_dst_port;
  logic [7:0]    eth_tx_data;
  logic          eth_tx_data_av, eth_tx_req;
  logic          eth_tx_req_rdy, eth_tx_data_rdy;

  always #5 clk50m = ~clk50m;

  udp_tx_scheduler #(.BUFFER_SIZE(BS), .RDY_TIMEOUT(32'(TMO))) dut (
    .clk50m(clk50m), .rst(rst),
    .req0(req0), .req1(req1), .ip0(ip0), .ip1(ip1),
    .port0(port0), .port1(port1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .busy(busy),
    .eth_tx_ip(eth_tx_ip), .eth_tx_dst_port(eth_tx_dst_port),
    .eth_tx_data(eth_tx_data), .eth_tx_data_av(eth_tx_data_av),
    .eth_tx_req(eth_tx_req), .eth_tx_req_rdy(eth_tx_req_rdy),
    .eth_tx_data_rdy(eth_tx_data_rdy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0 always ready, 1 random, 2 data_rdy toggles, 3 req_rdy stuck low

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]    edge_req;
  logic [BS-1:0] edge_dat [2];
  logic [31:0]   edge_ip  [2];
  logic [15:0]   edge_port[2];
  int            last_srv = 1;     // a tie grants the index that was not served last
  bit            in_frame = 0;
  int            cur_idx;
  logic [BS-1:0] exp_dat;
  logic [31:0]   exp_ip, done_ip;
  logic [15:0]   exp_port, done_port;
  bit            ip_bad;
  logic [7:0]    fbytes[$];
  int            fbyte_cyc[$];
  int            freq_cyc[$];
  int            served[$];
  int            ack_cyc, done_cyc, err_cyc;
  int            n_ack = 0, n_done = 0, n_errev = 0;

  // Snapshot of what the DUT sees on each rising edge (inputs only change #1 later).
  always @(posedge clk50m) begin
    cyc++;
    edge_req     = {req1, req0};
    edge_dat[0]  = data0;  edge_dat[1]  = data1;
    edge_ip[0]   = ip0;    edge_ip[1]   = ip1;
    edge_port[0] = port0;  edge_port[1] = port1;
    if (rst) begin
      in_frame = 0;
      last_srv = 1;
    end
  end

  always @(negedge clk50m) begin
    int gi;
    int bad;
    if (!rst) begin
      if (ack0 || ack1) begin
        gi = (edge_req == 2'b11) ? 1 - last_srv : (edge_req[1] ? 1 : 0);
        chk("ack_while_busy", in_frame, 1'b0);
        chk("ack_with_req", edge_req != 2'b00, 1'b1);
        chk("ack_grant", {ack1, ack0}, (gi == 1) ? 2'b10 : 2'b01);
        cur_idx  = gi;
        exp_dat  = edge_dat[gi];
        exp_ip   = edge_ip[gi];
        exp_port = edge_port[gi];
        ip_bad   = 0;
        fbytes.delete(); fbyte_cyc.delete(); freq_cyc.delete();
        in_frame = 1;
        ack_cyc  = cyc;
        served.push_back(gi);
        n_ack++;
      end
      if (eth_tx_data_av) begin
        if (in_frame) begin
          fbytes.push_back(eth_tx_data);
          fbyte_cyc.push_back(cyc);
        end else chk("av_outside_frame", eth_tx_data_av, 1'b0);
      end
      if (in_frame && (eth_tx_ip != exp_ip || eth_tx_dst_port != exp_port)) ip_bad = 1;
      if (eth_tx_req) begin
        if (in_frame) freq_cyc.push_back(cyc);
        else chk("req_outside_frame", eth_tx_req, 1'b0);
      end
      if (done0 || done1) begin
        chk("done_in_frame", in_frame, 1'b1);
        chk("done_idx", {done1, done0}, (cur_idx == 1) ? 2'b10 : 2'b01);
        chk("done_nbytes", fbytes.size(), NB);
        bad = 0;
        for (int i = 0; i < NB; i++)
          if (i < fbytes.size() && fbytes[i] != 8'(exp_dat >> (8 * (NB - 1 - i)))) bad++;
        chk("done_bytes", bad, 0);
        chk("done_nreq", freq_cyc.size(), 1);
        chk("done_dst_hold", ip_bad, 1'b0);
        done_ip   = eth_tx_ip;
        done_port = eth_tx_dst_port;
        last_srv  = cur_idx;
        in_frame  = 0;
        done_cyc  = cyc;
        n_done++;
      end
      if (err0 || err1) begin
        chk("err_in_frame", in_frame, 1'b1);
        chk("err_idx", {err1, err0}, (cur_idx == 1) ? 2'b10 : 2'b01);
        chk("err_nbytes", fbytes.size(), 0);
        chk("err_nreq", freq_cyc.size(), 0);
        last_srv = cur_idx;
        in_frame = 0;
        err_cyc  = cyc;
        n_errev++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk50m);
    #1;
    case (rdy_mode)
      0: begin eth_tx_req_rdy = 1'b1; eth_tx_data_rdy = 1'b1; end
      1: begin
        eth_tx_req_rdy  = ($urandom_range(0, 3) != 0);
        eth_tx_data_rdy = 1'($urandom_range(0, 1));
      end
      2: begin eth_tx_req_rdy = 1'b1; eth_tx_data_rdy = ~eth_tx_data_rdy; end
      default: begin eth_tx_req_rdy = 1'b0; eth_tx_data_rdy = 1'b1; end
    endcase
  endtask

  function automatic int ev_cnt(input int kind);
    return (kind == 0) ? n_ack : (kind == 1) ? n_done : n_errev;
  endfunction

  task automatic wait_ev(input string tag, input int kind, input int target, input int budget);
    int k = 0;
    while (ev_cnt(kind) < target && k < budget) begin
      step();
      k++;
    end
    if (ev_cnt(kind) < target) chk({tag, "_timeout"}, ev_cnt(kind), target);
  endtask

  function automatic logic [BS-1:0] rnd_dat();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  initial begin
    int c0, b, bd, nd, ne, nav, issued, k;
    logic [BS-1:0] got;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    ip0 = '0; ip1 = '0; port0 = '0; port1 = '0; data0 = '0; data1 = '0;
    eth_tx_req_rdy = 1'b1; eth_tx_data_rdy = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_pulses", {ack1, ack0, done1, done0, err1, err0}, 6'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_av", eth_tx_data_av, 1'b0);
    chk("rst_req", eth_tx_req, 1'b0);
    chk("rst_data", eth_tx_data, 8'h00);
    chk("rst_ip", eth_tx_ip, 32'h0);
    chk("rst_port", eth_tx_dst_port, 16'h0);
    rst = 1'b0;
    step();

    // Latency and byte order, core always ready
    rdy_mode = 0;
    data0 = 80'h7469727700112233_4455; ip0 = 32'h0A000001; port0 = 16'd5000;
    req0 = 1'b1; c0 = cyc;
    wait_ev("lat_ack", 0, n_ack + 1, 10);
    req0 = 1'b0;
    wait_ev("lat_done", 1, n_done + 1, 40);
    got = '0;
    foreach (fbytes[i]) got = {got[BS-9:0], fbytes[i]};
    chk("lat_bytes", got, 80'h7469727700112233_4455);
    chk("lat_ack_cyc", ack_cyc - c0, 1);
    chk("lat_first_byte", (fbyte_cyc.size() > 0) ? fbyte_cyc[0] - c0 : -1, 3);
    chk("lat_last_byte", (fbyte_cyc.size() == NB) ? fbyte_cyc[NB-1] - c0 : -1, NB + 2);
    chk("lat_req_cyc", (freq_cyc.size() > 0) ? freq_cyc[0] - c0 : -1, NB + 4);
    chk("lat_done_cyc", done_cyc - c0, NB + 5);

    // Both held from reset: strict alternation starting with req0
    rst = 1'b1; step(); step(); rst = 1'b0;
    data0 = rnd_dat(); data1 = rnd_dat(); ip1 = $urandom; port1 = 16'($urandom);
    b = served.size(); bd = n_done; c0 = n_ack;
    req0 = 1'b1; req1 = 1'b1;
    k = 0;
    while (n_done - bd < 4 && k < 300) begin
      step();
      if (n_ack - c0 >= 4) begin req0 = 1'b0; req1 = 1'b0; end
      k++;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) step();
    chk("alt_nack", n_ack - c0, 4);
    chk("alt_ndone", n_done - bd, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("alt_order%0d", i), (served.size() > b + i) ? served[b + i] : -1, i % 2);

    // data_rdy toggling during SEND
    rdy_mode = 2;
    data1 = rnd_dat(); req1 = 1'b1;
    wait_ev("tog_ack", 0, n_ack + 1, 10);
    req1 = 1'b0;
    wait_ev("tog_done", 1, n_done + 1, 60);
    chk("tog_nav", fbytes.size(), NB);
    rdy_mode = 0;
    step();

    // Destination held through done while requester inputs change mid-frame
    ip1 = 32'hC0A80A01; port1 = 16'd2390; data1 = rnd_dat(); req1 = 1'b1;
    wait_ev("hold_ack", 0, n_ack + 1, 10);
    req1 = 1'b0; ip1 = 32'h01020304; port1 = 16'd9999; data1 = rnd_dat();
    wait_ev("hold_done", 1, n_done + 1, 40);
    chk("hold_ip", done_ip, 32'hC0A80A01);
    chk("hold_port", done_port, 16'd2390);

    // Reset on the 5th byte
    data0 = rnd_dat(); req0 = 1'b1;
    wait_ev("rstm_ack", 0, n_ack + 1, 10);
    req0 = 1'b0;
    nav = 0; k = 0;
    while (nav < 5 && k < 40) begin
      if (eth_tx_data_av) nav++;
      if (nav < 5) step();
      k++;
    end
    chk("rstm_reached_5th", nav, 5);
    nd = n_done; ne = n_errev;
    rst = 1'b1;
    step();
    chk("rstm_av_low", eth_tx_data_av, 1'b0);
    chk("rstm_req_low", eth_tx_req, 1'b0);
    rst = 1'b0;
    repeat (20) step();
    chk("rstm_no_done", n_done, nd);
    chk("rstm_no_err", n_errev, ne);
    chk("rstm_idle", busy, 1'b0);
    data0 = rnd_dat(); req0 = 1'b1;
    wait_ev("rstm2_ack", 0, n_ack + 1, 10);
    req0 = 1'b0;
    wait_ev("rstm2_done", 1, nd + 1, 40);
    chk("rstm2_nbytes", fbytes.size(), NB);

    // Randomized traffic with random core backpressure
    rdy_mode = 1;
    issued = 0; bd = n_done; c0 = n_ack; k = 0;
    while (!(issued == 12 && !req0 && !req1 && !busy) && k < 4000) begin
      step();
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      if (!req0 && issued < 12 && $urandom_range(0, 3) == 0) begin
        data0 = rnd_dat(); ip0 = $urandom; port0 = 16'($urandom); req0 = 1'b1; issued++;
      end
      if (!req1 && issued < 12 && $urandom_range(0, 3) == 0) begin
        data1 = rnd_dat(); ip1 = $urandom; port1 = 16'($urandom); req1 = 1'b1; issued++;
      end
      k++;
    end
    step();
    chk("rnd_nack", n_ack - c0, 12);
    chk("rnd_ndone", n_done - bd, 12);
    rdy_mode = 0;
    step();

    // Ready timeout on requester 1
    rdy_mode = 3;
    nd = n_done;
    data1 = rnd_dat(); req1 = 1'b1;
    wait_ev("tmo_ack", 0, n_ack + 1, 10);
    req1 = 1'b0;
    wait_ev("tmo_err", 2, n_errev + 1, TMO + 50);
    chk("tmo_err_cyc", err_cyc - ack_cyc, TMO);
    chk("tmo_busy_after", busy, 1'b0);
    chk("tmo_no_done", n_done, nd);
    rdy_mode = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
